// File: rtl/accum5_seq.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | accum5_seq : issues a stored (Mode, A, B, Cin) program to accum5, one    |
// |              entry per clock, with an optional halt on overflow.        |
// | Revision   : 1.0                                                        |
// +-------------------------------------------------------------------------+
module accum5_seq #(
   parameter int DEPTH = 8,
   parameter int EW    = 13
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          WrEn,
   input  logic [2:0]    WrAddr,
   input  logic [EW-1:0] WrData,
   input  logic          Start,
   input  logic [3:0]    Len,
   input  logic          HaltOnOf,
   input  logic          Of,
   output logic [3:0]    A,
   output logic [3:0]    B,
   output logic          Cin,
   output logic [3:0]    Mode,
   output logic          Issue,
   output logic          Busy,
   output logic          Done,
   output logic          Halted,
   output logic [2:0]    PC
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2,
      S_HALT = 2'd3
   } state_t;

   localparam logic [3:0] c_max_len = 4'd8;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [EW-1:0] r_mem [DEPTH];
   logic [EW-1:0] r_entry;
   logic [EW-1:0] w_entry_nxt;
   logic          r_issue;
   logic          w_issue_nxt;
   logic          r_issue_dly;
   logic [2:0]    r_pc;
   logic [2:0]    w_pc_nxt;
   logic [3:0]    r_len;
   logic [3:0]    w_len_nxt;

   logic          w_busy;
   logic          w_wr_ok;
   logic          w_start_ok;
   logic          w_ovf;
   logic          w_last;
   logic [3:0]    w_len_clamped;
   logic [EW-1:0] w_fetch0;

   assign w_busy        = (r_state == S_RUN) || (r_state == S_DONE);
   assign w_wr_ok       = WrEn && !w_busy;
   assign w_start_ok    = Start && (Len != 4'd0) && !w_busy;
   assign w_ovf         = HaltOnOf && Of && r_issue_dly;
   assign w_last        = ({1'b0, r_pc} == (r_len - 4'd1));
   assign w_len_clamped = (Len > c_max_len) ? c_max_len : Len;
   // A write landing on the Start edge must already be visible in entry 0.
   assign w_fetch0      = (w_wr_ok && (WrAddr == 3'd0)) ? WrData : r_mem[0];

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_wr_ok) begin
         r_mem[WrAddr] <= WrData;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state     <= S_IDLE;
         r_entry     <= '0;
         r_issue     <= 1'b0;
         r_issue_dly <= 1'b0;
         r_pc        <= 3'd0;
         r_len       <= 4'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_entry     <= w_entry_nxt;
         r_issue     <= w_issue_nxt;
         r_issue_dly <= r_issue;
         r_pc        <= w_pc_nxt;
         r_len       <= w_len_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_entry_nxt = '0;
      w_issue_nxt = 1'b0;
      w_pc_nxt    = r_pc;
      w_len_nxt   = r_len;
      case (r_state)
         S_IDLE, S_HALT: begin
            if (w_start_ok) begin
               w_state_nxt = S_RUN;
               w_len_nxt   = w_len_clamped;
               w_pc_nxt    = 3'd0;
               w_entry_nxt = w_fetch0;
               w_issue_nxt = 1'b1;
            end
         end
         S_RUN: begin
            // Overflow wins over normal completion, even on the last entry.
            if (w_ovf) begin
               w_state_nxt = S_HALT;
            end else if (w_last) begin
               w_state_nxt = S_DONE;
            end else begin
               w_pc_nxt    = r_pc + 3'd1;
               w_entry_nxt = r_mem[r_pc + 3'd1];
               w_issue_nxt = 1'b1;
            end
         end
         S_DONE: begin
            w_state_nxt = w_ovf ? S_HALT : S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign {Mode, A, B, Cin} = r_entry;
   assign Issue  = r_issue;
   assign PC     = r_pc;
   assign Busy   = w_busy;
   assign Done   = (r_state == S_DONE);
   assign Halted = (r_state == S_HALT);

endmodule
`default_nettype wire
